// File: rtl/hssl_sync_monitor_if.sv
// HSSL sync monitor bus: receiver status in,
// link-sync status and reset request out.
interface hssl_sync_monitor_if #(
  parameter int NUM_LANES = 4
);
  logic                 rx_commadet_in;
  logic [NUM_LANES-1:0] rx_disperr_in;
  logic [NUM_LANES-1:0] rx_encerr_in;
  logic                 rx_vld_in;
  logic                 handshake_complete_in;
  logic [1:0]           loss_of_sync_state_out;
  logic                 loss_reset_out;
  logic [7:0]           inv_level_out;
  logic [15:0]          sync_loss_cnt_out;

  modport master (
    output rx_commadet_in,
    output rx_disperr_in,
    output rx_encerr_in,
    output rx_vld_in,
    output handshake_complete_in,
    input  loss_of_sync_state_out,
    input  loss_reset_out,
    input  inv_level_out,
    input  sync_loss_cnt_out
  );

  modport slave (
    input  rx_commadet_in,
    input  rx_disperr_in,
    input  rx_encerr_in,
    input  rx_vld_in,
    input  handshake_complete_in,
    output loss_of_sync_state_out,
    output loss_reset_out,
    output inv_level_out,
    output sync_loss_cnt_out
  );
endinterface

// File: rtl/hssl_sync_monitor.sv
// HSSL link sync monitor: loss/resync/acquired FSM,
// leaky error bucket, handshake watchdog with reset pulse.
// Option: HSSL_SYNC_REALIGN_CHECK_EN drops sync on a
// comma realign seen while SYNC_ACQUIRED.
module hssl_sync_monitor #(
  parameter int NUM_LANES         = 4,
  parameter int NUM_CLKC_FOR_SYNC = 4,
  parameter int NUM_VLD_PER_INV   = 4,
  parameter int NUM_INV_FOR_LOSS  = 8,
  parameter int HS_TIMEOUT_CYCLES = 1024,
  parameter int RST_PULSE_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  hssl_sync_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'b00,
    ST_RESYNC  = 2'b01,
    ST_LOSS    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  localparam int RCW =
    $clog2(NUM_CLKC_FOR_SYNC + 1);
  localparam int HTW =
    $clog2(HS_TIMEOUT_CYCLES + 1);
  localparam int PCW =
    $clog2(RST_PULSE_CYCLES + 1);

  localparam logic [RCW-1:0] RC_LAST =
    RCW'(NUM_CLKC_FOR_SYNC - 1);
  localparam logic [HTW-1:0] HT_LAST =
    HTW'(HS_TIMEOUT_CYCLES - 1);
  localparam logic [PCW-1:0] PC_LAST =
    PCW'(RST_PULSE_CYCLES - 1);
  localparam logic [8:0] BK_INC =
    9'(NUM_VLD_PER_INV);
  localparam logic [7:0] BK_LIM =
    8'(NUM_INV_FOR_LOSS);

  state_e          state_q, state_d;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic [HTW-1:0]  hs_q, hs_d;
  logic            pulse_q, pulse_d;
  logic [PCW-1:0]  pcnt_q, pcnt_d;
  logic [7:0]      lvl_q, lvl_d;
  logic [15:0]     lcnt_q, lcnt_d;

  logic [NUM_LANES-1:0] dis_w;
  logic [NUM_LANES-1:0] enc_w;
  logic                 invalid;
  logic                 hs_wait;
  logic                 timeout;
  logic                 lvl_hit;
  logic                 realign;
  logic                 sync_drop;
  logic [8:0]           lvl_sum;

  assign dis_w   = bus.rx_disperr_in;
  assign enc_w   = bus.rx_encerr_in;
  assign invalid = (|dis_w) | (|enc_w);

  assign hs_wait = (state_q == ST_SYNC) &&
                   !bus.handshake_complete_in;
  assign timeout = hs_wait && (hs_q == HT_LAST);
  assign lvl_hit = (lvl_q >= BK_LIM);
  assign lvl_sum = {1'b0, lvl_q} + BK_INC;

`ifdef HSSL_SYNC_REALIGN_CHECK_EN
  assign realign = bus.rx_commadet_in;
`else
  assign realign = 1'b0;
`endif

  // Next-state decode; illegal code falls back to LOSS.
  always_comb begin
    state_d   = state_q;
    sync_drop = 1'b0;
    case (state_q)
      ST_LOSS: begin
        if (bus.rx_commadet_in && !pulse_q)
          state_d = ST_RESYNC;
      end
      ST_RESYNC: begin
        if (invalid)
          state_d = ST_LOSS;
        else if (rcnt_q == RC_LAST)
          state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (timeout || lvl_hit || realign) begin
          state_d   = ST_LOSS;
          sync_drop = 1'b1;
        end
      end
      default: state_d = ST_LOSS;
    endcase
  end

  // Clean-cycle run length while resyncing.
  always_comb begin
    rcnt_d = '0;
    if (state_q == ST_RESYNC && !invalid)
      rcnt_d = rcnt_q + 1'b1;
  end

  // Handshake watchdog, only ticks while waiting.
  always_comb begin
    hs_d = '0;
    if (hs_wait && !timeout)
      hs_d = hs_q + 1'b1;
  end

  // Receiver reset pulse launched by the watchdog.
  always_comb begin
    pulse_d = pulse_q;
    pcnt_d  = pcnt_q;
    if (timeout) begin
      pulse_d = 1'b1;
      pcnt_d  = '0;
    end else if (pulse_q) begin
      if (pcnt_q == PC_LAST) begin
        pulse_d = 1'b0;
        pcnt_d  = '0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  // Leaky bucket; zero whenever not staying in sync.
  always_comb begin
    lvl_d = lvl_q;
    if (state_d != ST_SYNC) begin
      lvl_d = '0;
    end else if (invalid) begin
      lvl_d = lvl_sum[8] ? 8'hFF : lvl_sum[7:0];
    end else if (bus.rx_vld_in && lvl_q != 8'd0) begin
      lvl_d = lvl_q - 8'd1;
    end
  end

  // Saturating count of sync losses.
  always_comb begin
    lcnt_d = lcnt_q;
    if (sync_drop && lcnt_q != 16'hFFFF)
      lcnt_d = lcnt_q + 16'd1;
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOSS;
      rcnt_q  <= '0;
      hs_q    <= '0;
      pulse_q <= 1'b0;
      pcnt_q  <= '0;
      lvl_q   <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      hs_q    <= hs_d;
      pulse_q <= pulse_d;
      pcnt_q  <= pcnt_d;
      lvl_q   <= lvl_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign bus.loss_of_sync_state_out = state_q;
  assign bus.loss_reset_out         = pulse_q;
  assign bus.inv_level_out          = lvl_q;
  assign bus.sync_loss_cnt_out      = lcnt_q;

endmodule

// File: tb/tb_hssl_sync_monitor.sv
// Self-checking bench for hssl_sync_monitor:
// directed scenarios plus random traffic vs a model.
module tb_hssl_sync_monitor;

  localparam int NCLK  = 4;
  localparam int VINC  = 4;
  localparam int LIM   = 8;
  localparam int HS_TO = 1024;
  localparam int RSTP  = 16;
`ifdef HSSL_SYNC_REALIGN_CHECK_EN
  localparam bit REALIGN = 1'b1;
`else
  localparam bit REALIGN = 1'b0;
`endif

  logic clk;
  logic reset;
  hssl_sync_monitor_if #(.NUM_LANES(4)) bus();

  hssl_sync_monitor #(
    .NUM_LANES(4),
    .NUM_CLKC_FOR_SYNC(NCLK),
    .NUM_VLD_PER_INV(VINC),
    .NUM_INV_FOR_LOSS(LIM),
    .HS_TIMEOUT_CYCLES(HS_TO),
    .RST_PULSE_CYCLES(RSTP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model: state code, clean run, bucket,
  // wait cycles, pulse cycles left, loss count.
  int m_st = 2;
  int m_run = 0;
  int m_bkt = 0;
  int m_hs = 0;
  int m_pulse = 0;
  int m_cnt = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst,
                            input bit comma,
                            input bit inv,
                            input bit vld,
                            input bit hs);
    int st_n, run_n, bkt_n, hs_n, pulse_n, cnt_n;
    bit drop, tmo;
    if (rst) begin
      m_st = 2; m_run = 0; m_bkt = 0;
      m_hs = 0; m_pulse = 0; m_cnt = 0;
      return;
    end
    st_n = m_st; run_n = 0; bkt_n = 0; hs_n = 0;
    cnt_n = m_cnt; drop = 0; tmo = 0;
    pulse_n = (m_pulse > 0) ? m_pulse - 1 : 0;
    if (m_st == 1) begin
      if (inv) st_n = 2;
      else begin
        run_n = m_run + 1;
        if (run_n == NCLK) st_n = 0;
      end
    end else if (m_st == 0) begin
      hs_n = hs ? 0 : m_hs + 1;
      tmo = (hs_n == HS_TO);
      drop = tmo || (m_bkt >= LIM) ||
             (REALIGN && comma);
      if (drop) st_n = 2;
      if (tmo) pulse_n = RSTP;
      if (drop && m_cnt < 65535) cnt_n = m_cnt + 1;
    end else begin
      if (comma && m_pulse == 0) st_n = 1;
    end
    if (st_n == 0) begin
      if (inv)
        bkt_n = (m_bkt + VINC > 255) ? 255
                                     : m_bkt + VINC;
      else if (vld && m_bkt > 0)
        bkt_n = m_bkt - 1;
      else
        bkt_n = m_bkt;
    end
    if (st_n != 1) run_n = 0;
    if (st_n != 0) hs_n = 0;
    m_st = st_n; m_run = run_n; m_bkt = bkt_n;
    m_hs = hs_n; m_pulse = pulse_n; m_cnt = cnt_n;
  endtask

  task automatic tick(input bit rst,
                      input bit comma,
                      input logic [3:0] dis,
                      input logic [3:0] enc,
                      input bit vld,
                      input bit hs);
    reset                     = rst;
    bus.rx_commadet_in        = comma;
    bus.rx_disperr_in         = dis;
    bus.rx_encerr_in          = enc;
    bus.rx_vld_in             = vld;
    bus.handshake_complete_in = hs;
    @(posedge clk);
    model_step(rst, comma, (|dis) | (|enc), vld, hs);
    @(negedge clk);
  endtask

  task automatic clean(input bit hs);
    tick(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, hs);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", int'(bus.loss_of_sync_state_out),
          m_st);
      chk("rst_pulse", int'(bus.loss_reset_out),
          (m_pulse > 0) ? 1 : 0);
      chk("level", int'(bus.inv_level_out), m_bkt);
      chk("loss_cnt", int'(bus.sync_loss_cnt_out),
          m_cnt);
    end
  end

  int st;
  int hi;

  initial begin
    tick(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    cmp_en = 1'b1;
    tick(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
    chk("rst_state", int'(bus.loss_of_sync_state_out), 2);
    chk("rst_pulse0", int'(bus.loss_reset_out), 0);
    chk("rst_level", int'(bus.inv_level_out), 0);
    chk("rst_cnt", int'(bus.sync_loss_cnt_out), 0);

    // Acquire: comma then four clean cycles.
    tick(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("acq_comma", int'(bus.loss_of_sync_state_out), 1);
    for (int i = 0; i < 3; i++) begin
      clean(1'b1);
      chk("acq_run", int'(bus.loss_of_sync_state_out), 1);
    end
    clean(1'b1);
    chk("acq_done", int'(bus.loss_of_sync_state_out), 0);

    // One invalid word drained by four valid words.
    tick(1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b1);
    chk("leak_up", int'(bus.inv_level_out), 4);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
      chk("leak_dn", int'(bus.inv_level_out), 3 - i);
    end
    chk("leak_st", int'(bus.loss_of_sync_state_out), 0);

    // Two invalid words reach the loss limit.
    tick(1'b0, 1'b0, 4'h2, 4'h0, 1'b0, 1'b1);
    chk("lim_4", int'(bus.inv_level_out), 4);
    tick(1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b1);
    chk("lim_8", int'(bus.inv_level_out), 8);
    chk("lim_8st", int'(bus.loss_of_sync_state_out), 0);
    clean(1'b1);
    chk("lim_loss", int'(bus.loss_of_sync_state_out), 2);
    chk("lim_cnt", int'(bus.sync_loss_cnt_out), 1);

    // Error on third resync cycle aborts the run.
    tick(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
    clean(1'b1);
    clean(1'b1);
    tick(1'b0, 1'b0, 4'h0, 4'h4, 1'b0, 1'b1);
    chk("rs_abort", int'(bus.loss_of_sync_state_out), 2);
    tick(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) clean(1'b1);
    chk("rs_fresh", int'(bus.loss_of_sync_state_out), 1);
    clean(1'b1);
    chk("rs_sync", int'(bus.loss_of_sync_state_out), 0);

    // Comma while in sync.
    tick(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("realign", int'(bus.loss_of_sync_state_out),
        REALIGN ? 2 : 0);
    chk("realign_cnt", int'(bus.sync_loss_cnt_out),
        REALIGN ? 2 : 1);
    tick(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) clean(1'b1);
    chk("resync2", int'(bus.loss_of_sync_state_out), 0);

    // Handshake never completes: timeout and pulse.
    for (int i = 0; i < HS_TO - 1; i++)
      tick(1'b0, 1'b0, 4'h0, 4'h0,
           1'($urandom_range(1)), 1'b0);
    chk("to_pre", int'(bus.loss_of_sync_state_out), 0);
    clean(1'b0);
    chk("to_loss", int'(bus.loss_of_sync_state_out), 2);
    chk("to_pulse", int'(bus.loss_reset_out), 1);
    chk("to_cnt", int'(bus.sync_loss_cnt_out),
        REALIGN ? 3 : 2);
    hi = 1;
    for (int i = 0; i < RSTP; i++) begin
      tick(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
      hi += int'(bus.loss_reset_out);
    end
    chk("pulse_len", hi, RSTP);
    chk("pulse_hold", int'(bus.loss_of_sync_state_out), 2);
    tick(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("post_pulse", int'(bus.loss_of_sync_state_out), 1);

    // Reset in the middle of a reset pulse.
    for (int i = 0; i < NCLK; i++) clean(1'b1);
    for (int i = 0; i < HS_TO + 5; i++) clean(1'b0);
    chk("mid_pulse", int'(bus.loss_reset_out), 1);
    tick(1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("mid_rst_p", int'(bus.loss_reset_out), 0);
    chk("mid_rst_c", int'(bus.sync_loss_cnt_out), 0);
    tick(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("mid_comma", int'(bus.loss_of_sync_state_out), 1);

    // Random traffic against the model.
    begin
      bit hs_r;
      logic [3:0] d, e;
      hs_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(59) == 0) hs_r = ~hs_r;
        d = 4'h0;
        e = 4'h0;
        if ($urandom_range(11) == 0) d = 4'($urandom);
        if ($urandom_range(15) == 0) e = 4'($urandom);
        tick(($urandom_range(499) == 0),
             ($urandom_range(7) == 0),
             d, e, 1'($urandom_range(1)), hs_r);
      end
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
